// File: rtl/icb_dma_pkg.sv
// Shared definitions for the icb_dma word-copy engine: register map, CSR bits, FSM encodings.
package icb_dma_pkg;

  localparam logic [1:0] DMA_SRC = 2'd0;
  localparam logic [1:0] DMA_DST = 2'd1;
  localparam logic [1:0] DMA_LEN = 2'd2;
  localparam logic [1:0] DMA_CSR = 2'd3;

  localparam int CSR_START = 0;
  localparam int CSR_BUSY  = 0;
  localparam int CSR_DONE  = 1;
  localparam int CSR_ERR   = 2;
  localparam int CSR_IE    = 3;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RD_CMD = 3'd1;
  localparam logic [2:0] RD_RSP = 3'd2;
  localparam logic [2:0] WR_CMD = 3'd3;
  localparam logic [2:0] WR_RSP = 3'd4;

  function automatic logic [31:0] csr_word(input logic busy, input logic done,
                                           input logic err, input logic ie);
    logic [31:0] w;
    w = '0;
    w[CSR_BUSY] = busy;
    w[CSR_DONE] = done;
    w[CSR_ERR]  = err;
    w[CSR_IE]   = ie;
    return w;
  endfunction

endpackage

// File: rtl/icb_dma_if.sv
// ICB command/response bundle; master = initiator side, slave = responder side.
interface icb_dma_if #(parameter int ADDR_W = 32);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_read;
  logic [31:0]       cmd_wdata;
  logic [3:0]        cmd_wmask;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_err;
  logic [31:0]       rsp_rdata;

  modport master (
    output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/icb_dma_cfg.sv
// Config-port ICB responder and register file (SRC/DST/LEN/CSR); one-cycle registered response.
// ICB_DMA_IRQ_EN adds the CSR ie bit.
module icb_dma_cfg
  import icb_dma_pkg::*;
#(
  parameter int LEN_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  icb_dma_if.slave          cfg,
  input  logic              busy,
  input  logic              done_set,
  input  logic              err_set,
  output logic              start,
  output logic [ADDR_W-1:0] src,
  output logic [ADDR_W-1:0] dst,
  output logic [LEN_W-1:0]  len,
  output logic              done,
  output logic              err,
  output logic              ie
);

  logic        acc;
  logic        wr_ok;
  logic        csr_wr;
  logic [1:0]  idx;
  logic [31:0] rd_mux;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        unused_addr;

  assign idx           = cfg.cmd_addr[3:2];
  assign cfg.cmd_ready = !(rsp_valid && !cfg.rsp_ready);
  assign acc           = cfg.cmd_valid && cfg.cmd_ready;
  assign wr_ok         = acc && !cfg.cmd_read && (cfg.cmd_wmask == 4'hF);
  assign csr_wr        = wr_ok && (idx == DMA_CSR);
  assign start         = csr_wr && cfg.cmd_wdata[CSR_START] && !busy;
  assign cfg.rsp_valid = rsp_valid;
  assign cfg.rsp_rdata = rsp_rdata;
  assign cfg.rsp_err   = 1'b0;
  assign unused_addr   = ^{cfg.cmd_addr[ADDR_W-1:4], cfg.cmd_addr[1:0]};

  always_comb begin
    rd_mux = '0;
    case (idx)
      DMA_SRC: rd_mux = 32'(src);
      DMA_DST: rd_mux = 32'(dst);
      DMA_LEN: rd_mux = 32'(len);
      default: rd_mux = csr_word(busy, done, err, ie);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      src       <= '0;
      dst       <= '0;
      len       <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (acc) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= cfg.cmd_read ? rd_mux : 32'h0;
      end else if (cfg.rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      if (wr_ok && !busy) begin
        case (idx)
          DMA_SRC: src <= ADDR_W'(cfg.cmd_wdata) & ~ADDR_W'(3);
          DMA_DST: dst <= ADDR_W'(cfg.cmd_wdata) & ~ADDR_W'(3);
          DMA_LEN: len <= cfg.cmd_wdata[LEN_W-1:0];
          default: ;
        endcase
      end
      // A zero-length start completes immediately without touching the bus.
      if (done_set || (start && len == '0))
        done <= 1'b1;
      else if (start || (csr_wr && cfg.cmd_wdata[CSR_DONE]))
        done <= 1'b0;
      if (err_set)
        err <= 1'b1;
      else if (start || (csr_wr && cfg.cmd_wdata[CSR_ERR]))
        err <= 1'b0;
    end
  end

`ifdef ICB_DMA_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst)
      ie <= 1'b0;
    else if (csr_wr)
      ie <= cfg.cmd_wdata[CSR_IE];
  end
`else
  assign ie = 1'b0;
`endif

endmodule

// File: rtl/icb_dma.sv
// Single-channel ICB word-copy DMA: alternating single-beat read/write, one beat outstanding.
// ICB_DMA_IRQ_EN adds dma_irq_o (registered done & ie).
module icb_dma
  import icb_dma_pkg::*;
#(
  parameter int LEN_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic      clk,
  input  logic      rst,
  icb_dma_if.slave  cfg,
  icb_dma_if.master dma
`ifdef ICB_DMA_IRQ_EN
  , output logic    dma_irq_o
`endif
);

  logic [2:0]        state;
  logic [ADDR_W-1:0] cur_src, cur_dst, cmd_addr, src, dst;
  logic [LEN_W-1:0]  remaining, len;
  logic              cmd_valid, cmd_read;
  logic [31:0]       data_buf;
  logic              start, busy, done_set, err_set, done, err, ie;

  assign busy = (state != IDLE);

  icb_dma_cfg #(.LEN_W(LEN_W), .ADDR_W(ADDR_W)) u_cfg (
    .clk      (clk),
    .rst      (rst),
    .cfg      (cfg),
    .busy     (busy),
    .done_set (done_set),
    .err_set  (err_set),
    .start    (start),
    .src      (src),
    .dst      (dst),
    .len      (len),
    .done     (done),
    .err      (err),
    .ie       (ie)
  );

  assign dma.cmd_valid = cmd_valid;
  assign dma.cmd_addr  = cmd_addr;
  assign dma.cmd_read  = cmd_read;
  assign dma.cmd_wdata = data_buf;
  assign dma.cmd_wmask = cmd_read ? 4'h0 : 4'hF;
  assign dma.rsp_ready = 1'b1;

  always_comb begin
    done_set = 1'b0;
    err_set  = 1'b0;
    if (dma.rsp_valid && (state == RD_RSP || state == WR_RSP)) begin
      if (dma.rsp_err) begin
        done_set = 1'b1;
        err_set  = 1'b1;
      end else if (state == WR_RSP && remaining == LEN_W'(1)) begin
        done_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_valid <= 1'b0;
      cmd_read  <= 1'b0;
      cmd_addr  <= '0;
      cur_src   <= '0;
      cur_dst   <= '0;
      remaining <= '0;
      data_buf  <= '0;
    end else begin
      case (state)
        IDLE: if (start && len != '0) begin
          cur_src   <= src;
          cur_dst   <= dst;
          remaining <= len;
          cmd_addr  <= src;
          cmd_read  <= 1'b1;
          cmd_valid <= 1'b1;
          state     <= RD_CMD;
        end
        RD_CMD: if (dma.cmd_ready) begin
          cmd_valid <= 1'b0;
          state     <= RD_RSP;
        end
        RD_RSP: if (dma.rsp_valid) begin
          if (dma.rsp_err) begin
            state <= IDLE;
          end else begin
            data_buf  <= dma.rsp_rdata;
            cmd_addr  <= cur_dst;
            cmd_read  <= 1'b0;
            cmd_valid <= 1'b1;
            state     <= WR_CMD;
          end
        end
        WR_CMD: if (dma.cmd_ready) begin
          cmd_valid <= 1'b0;
          state     <= WR_RSP;
        end
        WR_RSP: if (dma.rsp_valid) begin
          if (dma.rsp_err) begin
            state <= IDLE;
          end else begin
            cur_src   <= cur_src + ADDR_W'(4);
            cur_dst   <= cur_dst + ADDR_W'(4);
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              state <= IDLE;
            end else begin
              cmd_addr  <= cur_src + ADDR_W'(4);
              cmd_read  <= 1'b1;
              cmd_valid <= 1'b1;
              state     <= RD_CMD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ICB_DMA_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst)
      dma_irq_o <= 1'b0;
    else
      dma_irq_o <= done & ie;
  end
`else
  logic unused_irq;
  assign unused_irq = done ^ ie;
`endif

  logic unused_err;
  assign unused_err = err;

endmodule

// File: tb/tb_icb_dma.sv
// Directed self-checking bench for icb_dma with a zero-wait memory responder that can stall or fault.
module tb_icb_dma;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icb_dma_if #(.ADDR_W(32)) cfg_bus ();
  icb_dma_if #(.ADDR_W(32)) dma_bus ();
`ifdef ICB_DMA_IRQ_EN
  logic dma_irq_o;
`endif

  icb_dma #(.LEN_W(16), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .cfg (cfg_bus),
    .dma (dma_bus)
`ifdef ICB_DMA_IRQ_EN
    , .dma_irq_o (dma_irq_o)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // memory responder state
  logic [31:0] mem [0:255];
  int          stall_max = 0;
  bit          hold_writes = 1'b0;
  int          err_read_idx = -1;
  int          rd_count = 0;
  int          wr_count = 0;
  int          valid_cycles = 0;
  logic [32:0] log_q [$];
  logic        pend = 1'b0;
  logic        pend_err = 1'b0;
  logic [31:0] pend_data = '0;
  int          stall_cnt = 0;
  bit          stalled = 1'b0;
  logic [31:0] snap_addr, snap_wdata;
  logic [4:0]  snap_ctl;

  function automatic logic [31:0] pat(input int i);
    return {8'hA5, 8'(i), 16'(i * 7 + 3)};
  endfunction

  initial begin
    dma_bus.cmd_ready = 1'b0;
    dma_bus.rsp_valid = 1'b0;
    dma_bus.rsp_err   = 1'b0;
    dma_bus.rsp_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0;
        stalled = 1'b0;
        stall_cnt = 0;
        dma_bus.rsp_valid = 1'b0;
        dma_bus.cmd_ready = 1'b0;
        continue;
      end
      dma_bus.rsp_valid = pend;
      dma_bus.rsp_err   = pend_err;
      dma_bus.rsp_rdata = pend_data;
      pend = 1'b0;
      if (dma_bus.cmd_valid) begin
        valid_cycles++;
        if (stalled) begin
          check("stall_addr", dma_bus.cmd_addr, snap_addr);
          check("stall_wdata", dma_bus.cmd_wdata, snap_wdata);
          check("stall_ctl", 32'({dma_bus.cmd_read, dma_bus.cmd_wmask}), 32'(snap_ctl));
        end else begin
          stall_cnt = (stall_max > 0) ? int'($urandom_range(0, stall_max)) : 0;
        end
        dma_bus.cmd_ready = (stall_cnt == 0) && !(hold_writes && !dma_bus.cmd_read);
        if (stall_cnt > 0) stall_cnt--;
        if (dma_bus.cmd_ready) begin
          stalled = 1'b0;
          log_q.push_back({dma_bus.cmd_read, dma_bus.cmd_addr});
          if (dma_bus.cmd_read) begin
            rd_count++;
            pend_data = mem[dma_bus.cmd_addr[9:2]];
            pend_err  = (rd_count == err_read_idx);
          end else begin
            wr_count++;
            if (dma_bus.cmd_wmask == 4'hF) mem[dma_bus.cmd_addr[9:2]] = dma_bus.cmd_wdata;
            pend_data = '0;
            pend_err  = 1'b0;
          end
          pend = 1'b1;
        end else begin
          stalled    = 1'b1;
          snap_addr  = dma_bus.cmd_addr;
          snap_wdata = dma_bus.cmd_wdata;
          snap_ctl   = {dma_bus.cmd_read, dma_bus.cmd_wmask};
        end
      end else begin
        dma_bus.cmd_ready = 1'b0;
        stalled = 1'b0;
      end
    end
  end

  // Config transfer; called and returns at a negedge (the one right after the accept edge).
  task automatic cfg_xfer(input logic rd, input logic [31:0] addr, input logic [31:0] data,
                          output logic [31:0] rdata);
    int n = 0;
    cfg_bus.cmd_valid = 1'b1;
    cfg_bus.cmd_read  = rd;
    cfg_bus.cmd_addr  = addr;
    cfg_bus.cmd_wdata = data;
    cfg_bus.cmd_wmask = 4'hF;
    while (!cfg_bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("cfg_accept_timeout", 32'(n), 32'd0);
    @(negedge clk);
    cfg_bus.cmd_valid = 1'b0;
    rdata = cfg_bus.rsp_rdata;
  endtask

  task automatic wr(input logic [1:0] r, input logic [31:0] d);
    logic [31:0] x;
    cfg_xfer(1'b0, 32'(r) << 2, d, x);
  endtask

  task automatic rdr(input logic [1:0] r, output logic [31:0] d);
    cfg_xfer(1'b1, 32'(r) << 2, 32'h0, d);
  endtask

  task automatic wait_done(output logic [31:0] csr);
    int n = 0;
    rdr(2'd3, csr);
    while (csr[0] && n < 400) begin
      rdr(2'd3, csr);
      n++;
    end
    check("busy_cleared", 32'(csr[0]), 32'd0);
  endtask

  logic [31:0] v;
  int base_vc, base_wr;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = pat(i);
    rst = 1'b1;
    cfg_bus.cmd_valid = 1'b0;
    cfg_bus.cmd_read  = 1'b0;
    cfg_bus.cmd_addr  = '0;
    cfg_bus.cmd_wdata = '0;
    cfg_bus.cmd_wmask = '0;
    cfg_bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dma_valid", 32'(dma_bus.cmd_valid), 32'd0);
    check("rst_cfg_rsp_valid", 32'(cfg_bus.rsp_valid), 32'd0);
    check("rst_cfg_rdata", cfg_bus.rsp_rdata, 32'd0);
`ifdef ICB_DMA_IRQ_EN
    check("rst_irq", 32'(dma_irq_o), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    rdr(2'd3, v); check("rst_csr", v, 32'h0);
    rdr(2'd0, v); check("rst_src", v, 32'h0);
    rdr(2'd2, v); check("rst_len", v, 32'h0);

    // register readback boundaries
    wr(2'd0, 32'h2000_0003); rdr(2'd0, v); check("src_lowbits", v, 32'h2000_0000);
    wr(2'd2, 32'h0001_0005); rdr(2'd2, v); check("len_trunc", v, 32'h0000_0005);

    // 1: basic copy of 4 words
    log_q.delete();
    wr(2'd0, 32'h2000_0000); wr(2'd1, 32'h2000_0100); wr(2'd2, 32'd4);
    wr(2'd3, 32'h1);
    wait_done(v);
    check("t1_csr", v, 32'h2);
    check("t1_ncmds", 32'(log_q.size()), 32'd8);
    for (int i = 0; i < 4 && 2 * i + 1 < log_q.size(); i++) begin
      check("t1_rd_cmd", 32'(log_q[2*i]), 32'h2000_0000 + 32'(4 * i));
      check("t1_rd_flag", 32'(log_q[2*i][32]), 32'd1);
      check("t1_wr_cmd", 32'(log_q[2*i+1]), 32'h2000_0100 + 32'(4 * i));
      check("t1_wr_flag", 32'(log_q[2*i+1][32]), 32'd0);
    end
    for (int i = 0; i < 4; i++) check("t1_data", mem[64 + i], pat(i));
    rdr(2'd0, v); check("t1_src_kept", v, 32'h2000_0000);

    // 2: zero length
    wr(2'd2, 32'd0);
    base_vc = valid_cycles;
    wr(2'd3, 32'h1);
    rdr(2'd3, v); check("t2_csr", v, 32'h2);
    repeat (5) @(negedge clk);
    check("t2_no_traffic", 32'(valid_cycles - base_vc), 32'd0);

    // 3: error on the second read
    wr(2'd0, 32'h2000_0080); wr(2'd1, 32'h2000_0180); wr(2'd2, 32'd3);
    err_read_idx = rd_count + 2;
    base_wr = wr_count;
    wr(2'd3, 32'h1);
    wait_done(v);
    check("t3_csr", v, 32'h6);
    check("t3_writes", 32'(wr_count - base_wr), 32'd1);
    check("t3_word0", mem[96], pat(32));
    check("t3_word1_untouched", mem[97], pat(97));
    wr(2'd3, 32'h6);
    rdr(2'd3, v); check("t3_w1c", v, 32'h0);
    err_read_idx = -1;

    // 4: random stalls, writes while busy ignored
    stall_max = 5;
    wr(2'd0, 32'h2000_0040); wr(2'd1, 32'h2000_0200); wr(2'd2, 32'd8);
    wr(2'd3, 32'h1);
    wr(2'd0, 32'h2000_0300);
    wr(2'd2, 32'd5);
    rdr(2'd0, v); check("t4_src_locked", v, 32'h2000_0040);
    rdr(2'd2, v); check("t4_len_locked", v, 32'd8);
    rdr(2'd3, v); check("t4_busy", v, 32'h1);
    wait_done(v);
    check("t4_csr", v, 32'h2);
    for (int i = 0; i < 8; i++) check("t4_data", mem[128 + i], pat(16 + i));
    stall_max = 0;

    // 5: reset while a write command is pending
    hold_writes = 1'b1;
    wr(2'd0, 32'h2000_0000); wr(2'd1, 32'h2000_0300); wr(2'd2, 32'd2);
    wr(2'd3, 32'h1);
    begin
      int n = 0;
      while (!(dma_bus.cmd_valid && !dma_bus.cmd_read) && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("t5_reach_wr_cmd", 32'(dma_bus.cmd_valid && !dma_bus.cmd_read), 32'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    check("t5_valid_dropped", 32'(dma_bus.cmd_valid), 32'd0);
    check("t5_cfg_rsp_valid", 32'(cfg_bus.rsp_valid), 32'd0);
    rst = 1'b0;
    hold_writes = 1'b0;
    @(negedge clk);
    rdr(2'd3, v); check("t5_csr", v, 32'h0);
    rdr(2'd0, v); check("t5_src", v, 32'h0);
    check("t5_no_write", mem[192], pat(192));
    wr(2'd0, 32'h2000_0020); wr(2'd1, 32'h2000_0340); wr(2'd2, 32'd2);
    wr(2'd3, 32'h1);
    wait_done(v);
    check("t5_restart_csr", v, 32'h2);
    check("t5_data0", mem[208], pat(8));
    check("t5_data1", mem[209], pat(9));

`ifdef ICB_DMA_IRQ_EN
    // 6: interrupt
    wr(2'd0, 32'h2000_00A0); wr(2'd1, 32'h2000_03A0); wr(2'd2, 32'd2);
    wr(2'd3, 32'h9);
    check("t6_irq_busy", 32'(dma_irq_o), 32'd0);
    wait_done(v);
    check("t6_csr_ie", v, 32'hA);
    check("t6_irq_high", 32'(dma_irq_o), 32'd1);
    wr(2'd3, 32'hA);
    check("t6_irq_lag", 32'(dma_irq_o), 32'd1);
    @(negedge clk);
    check("t6_irq_low", 32'(dma_irq_o), 32'd0);
    wr(2'd1, 32'h2000_03C0);
    wr(2'd3, 32'h1);
    wait_done(v);
    check("t6_csr_noie", v, 32'h2);
    @(negedge clk);
    check("t6_irq_off", 32'(dma_irq_o), 32'd0);
    check("t6_data", mem[241], pat(41));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
